contador_salidas: RTL and testbench
===================================

Name: contador_salidas

Overview:
- Downstream statistics stage on the four output FIFOs (fifo4..fifo7) of the integracion datapath.
- Counts valid words popped from each output FIFO.
- Returns the selected count to the probador through a req/idx read handshake.
- Reads are honoured only while the main FSM reports IDLE, so counts are stable at read time.

Parameters:
- CNT_WIDTH, 5, width of each per-channel counter and of data_out.
- SATURATE, 0, 0 = counters wrap at 2^CNT_WIDTH-1 -> 0; 1 = counters hold at max.
- CLR_ON_READ, 0, 1 = the counter selected by a granted read is cleared on the grant edge.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
- pop4, pop5, pop6, pop7  input  1 each  pop strobes to output FIFOs 4..7.
- empty4, empty5, empty6, empty7  input  1 each  empty flags of output FIFOs 4..7.
- idle  input  1  high while the main FSM is in IDLE.
- req  input  1  read request from the probador.
- idx  input  2  channel select for the read: 0->fifo4, 1->fifo5, 2->fifo6, 3->fifo7.
- data_out  output  CNT_WIDTH  count returned for the read.
- valid  output  1  data_out is meaningful this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - all four counters = 0, data_out = 0, valid = 0, FSM = COUNT.
  - Reset asserted mid-read drops valid immediately; no partial result survives.
  - After reset deasserts, the first active edge behaves as a normal COUNT cycle.
- Counting, per channel n, evaluated every rising edge:
  - inc_n = pop_n & ~empty_n. A pop on an empty FIFO is not counted.
  - Wrap mode (SATURATE=0): 31 + 1 -> 0.
  - Saturate mode (SATURATE=1): 31 stays 31.
  - Counting never stops for reads; the counters run in all FSM states.
- FSM states:
  - COUNT: valid = 0, data_out = 0.
  - REPORT: valid = 1, data_out = captured value.
- Transitions:
  - COUNT -> REPORT when req & idle at the edge.
  - REPORT -> REPORT when req & idle is still true. Each cycle data_out is refreshed with counter[idx] as sampled at that edge, so idx may change every cycle.
  - REPORT -> COUNT when req=0 or idle=0. valid falls the cycle after, and data_out returns to 0.
- Latency: exactly 1 cycle from req sampled high to valid=1.
- Capture semantics: data_out takes the pre-increment value of the counter at the capture edge. A pop on that same edge appears in the next read.
- CLR_ON_READ=1:
  - The selected counter is loaded with inc_n on the grant edge (0, or 1 if a pop coincides).
  - Held req re-reads the cleared value each cycle.
  - Unselected counters are unaffected.
- req with idle=0 is ignored: no valid, no clear.
- Simultaneous pops on all four channels in one cycle increment all four counters independently.
- Outputs are registered; there is no combinational path from inputs to data_out or valid.

Decomposition:
- Shared package / include file `contador_defs`:
  - CNT_WIDTH default.
  - NUM_CH = 4.
  - State encodings COUNT = 1'b0, REPORT = 1'b1.
  - idx-to-channel constants CH4..CH7 = 0..3.
- One natural sub-module, `contador_canal`:
  - Ports: clk, reset, inc, clr, q.
  - Implements wrap/saturate and clear-with-coincident-increment.
  - Instantiated four times.
- The top level holds the FSM, the idx mux and the output registers.

Test Plan:
- Reset then 7 pops on fifo5 (empty5=0), then req=1, idx=1, idle=1 for one cycle -> valid=1 with data_out=7 exactly one cycle later; valid=0 and data_out=0 on the following cycle.
- 3 pops on fifo6 with empty6=1 plus 2 with empty6=0; read idx=2 -> data_out=2.
- 33 pops on fifo4:
  - SATURATE=0 -> read idx=0 gives data_out=1.
  - SATURATE=1 -> data_out=31.
- Hold req=1 with idle=1, step idx 0,1,2,3 after loading counts 4,5,6,7 -> valid held high and data_out=4,5,6,7 on consecutive cycles.
  - Then idle=0 -> valid=0 next cycle.
- CLR_ON_READ=1, counter7=9, grant read idx=3 while pop7=1, empty7=0 -> data_out=9; an immediate re-read gives 1.
  - Separately, assert reset=0 while valid=1 between clock edges -> valid and data_out go to 0 without waiting for clk.

Source files
------------

// File: rtl/contador_defs.sv
// Shared definitions for the output-FIFO statistics stage.
package contador_defs;

    // Default width of each per-channel counter and of data_out.
    localparam int CNT_WIDTH_DEF = 5;

    // Number of output FIFOs watched (fifo4..fifo7).
    localparam int NUM_CH = 4;

    // Read FSM encodings.
    localparam logic COUNT  = 1'b0;
    localparam logic REPORT = 1'b1;

    // idx values selecting each output FIFO.
    localparam logic [1:0] CH4 = 2'd0;
    localparam logic [1:0] CH5 = 2'd1;
    localparam logic [1:0] CH6 = 2'd2;
    localparam logic [1:0] CH7 = 2'd3;

endpackage

// File: rtl/contador_canal.sv
// One per-channel pop counter: wrap or saturate at max, and a clear that
// still honours an increment arriving on the same edge.
module contador_canal
    import contador_defs::*;
#(
    parameter int W        = CNT_WIDTH_DEF,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    // Counter update: clear (loading the coincident increment), else count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= {{(W-1){1'b0}}, inc};
        end else if (inc) begin
            if (SATURATE && (q == MAX_VAL)) begin
                q <= q;
            end else begin
                q <= q + ONE;
            end
        end
    end

endmodule

// File: rtl/contador_salidas.sv
// Statistics stage on output FIFOs 4..7: counts valid pops per FIFO and
// returns a selected count to the probador through a req/idx read.
//
// Read handshake: a read is granted on any rising edge where req & idle is
// high; the count of channel idx, as it stood before that edge's increment,
// appears on data_out with valid=1 in the following cycle. Holding req & idle
// high re-grants every cycle (idx may change each cycle). When req or idle is
// low at an edge, valid is 0 and data_out is 0 in the following cycle. There
// is no back-pressure: the probador must take the data while valid is high.
module contador_salidas
    import contador_defs::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter bit SATURATE    = 1'b0,
    parameter bit CLR_ON_READ = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pop4,
    input  logic                 pop5,
    input  logic                 pop6,
    input  logic                 pop7,
    input  logic                 empty4,
    input  logic                 empty5,
    input  logic                 empty6,
    input  logic                 empty7,
    input  logic                 idle,
    input  logic                 req,
    input  logic [1:0]           idx,
    output logic [CNT_WIDTH-1:0] data_out,
    output logic                 valid
);

    logic [NUM_CH-1:0]    inc;
    logic [NUM_CH-1:0]    clr;
    logic [CNT_WIDTH-1:0] cnt [NUM_CH];
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic                 grant;
    logic                 state;

    // A pop on an empty FIFO moves no data, so it is not counted.
    assign inc = {pop7 & ~empty7, pop6 & ~empty6, pop5 & ~empty5, pop4 & ~empty4};

    // Reads are only honoured while the main FSM sits in IDLE.
    assign grant = req & idle;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_canal
        assign clr[n] = CLR_ON_READ & grant & (idx == 2'(n));

        contador_canal #(
            .W        (CNT_WIDTH),
            .SATURATE (SATURATE)
        ) u_canal (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[n]),
            .clr   (clr[n]),
            .q     (cnt[n])
        );
    end

    // Channel select for the read path.
    always_comb begin
        sel_cnt = '0;
        case (idx)
            CH4:     sel_cnt = cnt[0];
            CH5:     sel_cnt = cnt[1];
            CH6:     sel_cnt = cnt[2];
            CH7:     sel_cnt = cnt[3];
            default: sel_cnt = '0;
        endcase
    end

    // Read FSM: REPORT for exactly the cycles following a granted edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COUNT;
        end else if (grant) begin
            state <= REPORT;
        end else begin
            state <= COUNT;
        end
    end

    // Output data register: captured count while reporting, zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (grant) begin
            data_out <= sel_cnt;
        end else begin
            data_out <= '0;
        end
    end

    // valid is the registered FSM state, so it never depends on inputs
    // combinationally.
    assign valid = (state == REPORT);

endmodule

// File: tb/tb_contador_salidas.sv
// Directed bench for contador_salidas: three instances (wrap, saturate,
// clear-on-read) share one stimulus stream.
module tb_contador_salidas;

    localparam int W = 5;

    logic         clk;
    logic         reset;
    logic [3:0]   pop_v;
    logic [3:0]   empty_v;
    logic         idle;
    logic         req;
    logic [1:0]   idx;

    logic [W-1:0] data_a, data_s, data_c;
    logic         valid_a, valid_s, valid_c;

    int total;
    int bad;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    contador_salidas #(.CNT_WIDTH(W), .SATURATE(1'b0), .CLR_ON_READ(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .pop4(pop_v[0]), .pop5(pop_v[1]), .pop6(pop_v[2]), .pop7(pop_v[3]),
        .empty4(empty_v[0]), .empty5(empty_v[1]), .empty6(empty_v[2]), .empty7(empty_v[3]),
        .idle(idle), .req(req), .idx(idx), .data_out(data_a), .valid(valid_a)
    );

    contador_salidas #(.CNT_WIDTH(W), .SATURATE(1'b1), .CLR_ON_READ(1'b0)) dut_s (
        .clk(clk), .reset(reset),
        .pop4(pop_v[0]), .pop5(pop_v[1]), .pop6(pop_v[2]), .pop7(pop_v[3]),
        .empty4(empty_v[0]), .empty5(empty_v[1]), .empty6(empty_v[2]), .empty7(empty_v[3]),
        .idle(idle), .req(req), .idx(idx), .data_out(data_s), .valid(valid_s)
    );

    contador_salidas #(.CNT_WIDTH(W), .SATURATE(1'b0), .CLR_ON_READ(1'b1)) dut_c (
        .clk(clk), .reset(reset),
        .pop4(pop_v[0]), .pop5(pop_v[1]), .pop6(pop_v[2]), .pop7(pop_v[3]),
        .empty4(empty_v[0]), .empty5(empty_v[1]), .empty6(empty_v[2]), .empty7(empty_v[3]),
        .idle(idle), .req(req), .idx(idx), .data_out(data_c), .valid(valid_c)
    );

    // comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    // n valid-or-invalid pops on channel ch (0..3 = fifo4..fifo7)
    task automatic do_pops(input int ch, input int n, input logic emp);
        for (int k = 0; k < n; k++) begin
            pop_v[ch]   = 1'b1;
            empty_v[ch] = emp;
            step();
        end
        pop_v[ch]   = 1'b0;
        empty_v[ch] = 1'b0;
    endtask

    task automatic read_once(input logic [1:0] ch);
        req  = 1'b1;
        idle = 1'b1;
        idx  = ch;
        step();
        req  = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        pop_v   = '0;
        empty_v = '0;
        idle    = 1'b0;
        req     = 1'b0;
        idx     = 2'd0;

        // reset state
        #12;
        check("rst_valid_a", 32'(valid_a), 0);
        check("rst_data_a",  32'(data_a),  0);
        check("rst_valid_c", 32'(valid_c), 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("post_rst_valid", 32'(valid_a), 0);

        // 7 pops on fifo5, single-cycle read with 1-cycle latency
        do_pops(1, 7, 1'b0);
        req  = 1'b1;
        idle = 1'b1;
        idx  = 2'd1;
        #1;
        check("no_comb_valid", 32'(valid_a), 0);
        check("no_comb_data",  32'(data_a),  0);
        step();
        req = 1'b0;
        check("rd5_valid", 32'(valid_a), 1);
        check("rd5_data",  32'(data_a),  7);
        step();
        check("rd5_valid_drop", 32'(valid_a), 0);
        check("rd5_data_drop",  32'(data_a),  0);

        // pops on empty fifo6 are ignored
        pulse_reset();
        do_pops(2, 3, 1'b1);
        do_pops(2, 2, 1'b0);
        read_once(2'd2);
        check("rd6_data", 32'(data_a), 2);

        // 33 pops on fifo4: wrap vs saturate
        pulse_reset();
        do_pops(0, 33, 1'b0);
        read_once(2'd0);
        check("wrap_data",  32'(data_a), 1);
        check("sat_data",   32'(data_s), 31);
        check("sat_valid",  32'(valid_s), 1);

        // simultaneous pops load 4,5,6,7; held read steps idx
        pulse_reset();
        for (int k = 0; k < 7; k++) begin
            for (int n = 0; n < 4; n++) pop_v[n] = (k < n + 4);
            step();
        end
        pop_v = '0;
        req   = 1'b1;
        idle  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            idx = 2'(n);
            step();
            check("held_valid", 32'(valid_a), 1);
            check("held_data",  32'(data_a),  32'(n + 4));
        end
        idle = 1'b0;
        step();
        check("idle_drop_valid", 32'(valid_a), 0);
        check("idle_drop_data",  32'(data_a),  0);
        check("idle_drop_valid_c", 32'(valid_c), 0);
        req = 1'b0;
        read_once(2'd3);
        check("no_clear_a", 32'(data_a), 7);

        // clear-on-read with coincident pop on fifo7
        pulse_reset();
        do_pops(3, 9, 1'b0);
        req        = 1'b1;
        idle       = 1'b1;
        idx        = 2'd3;
        pop_v[3]   = 1'b1;
        step();
        pop_v[3]   = 1'b0;
        check("clr_first_c", 32'(data_c), 9);
        check("clr_first_a", 32'(data_a), 9);
        step();
        check("clr_reread_c", 32'(data_c), 1);
        check("clr_reread_a", 32'(data_a), 10);
        check("clr_reread_v", 32'(valid_c), 1);

        // asynchronous reset while valid is high
        #2;
        reset = 1'b0;
        #1;
        check("async_valid_a", 32'(valid_a), 0);
        check("async_data_a",  32'(data_a),  0);
        check("async_valid_c", 32'(valid_c), 0);
        req   = 1'b0;
        reset = 1'b1;
        step();
        check("after_rst_valid", 32'(valid_a), 0);
        read_once(2'd3);
        check("after_rst_cnt", 32'(data_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
